ram_wr_port_ctrl: RTL and testbench

- Owns the single write port of one on-chip RAM and is the only block that drives it.
- After reset it sweeps every address with a latched fill value. It then arbitrates two user write requesters (A, B) round-robin.
- A flush request re-runs the fill sweep at any time.
- It sits in front of the RAM macro in DMA descriptor/status tables, replacing per-table ad-hoc init and mux logic.

---
 rtl/ram_wr_port_ctrl_pkg.sv | 10 +
 rtl/ram_wr_port_ctrl_arb.sv | 14 +
 rtl/ram_wr_port_ctrl.sv | 111 +++++++++++
 tb/tb_ram_wr_port_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ram_wr_port_ctrl_pkg.sv
// ram_wr_port_ctrl_pkg: state encoding, grant IDs and address-width helper
// shared by the RAM write-port controller and other RAM wrappers.
package ram_wr_port_ctrl_pkg;
    typedef enum logic [1:0] {INIT_START, SWEEP, READY} ctrlState;
    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;
    function automatic int addrWidthOf(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/ram_wr_port_ctrl_arb.sv
// rr_arb2: combinational two-way round-robin arbiter; a tie goes to the
// requester that did not win last time.
module rr_arb2
    import ram_wr_port_ctrl_pkg::*;
(
    input  logic reqA,
    input  logic reqB,
    input  logic lastGrant,
    output logic grantA,
    output logic grantB
);
    assign grantA = reqA && (!reqB || lastGrant == GRANT_B);
    assign grantB = reqB && (!reqA || lastGrant == GRANT_A);
endmodule

// File: rtl/ram_wr_port_ctrl.sv
// ram_wr_port_ctrl: sole driver of a RAM write port; fills every word after
// reset or flush, then round-robins writes from requesters A and B.
module ram_wr_port_ctrl
    import ram_wr_port_ctrl_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DATAWIDTH = 32,
    localparam int ADDRWIDTH = addrWidthOf(DEPTH)
) (
    input  logic                 clockCore,
    input  logic                 resetCore,
    input  logic [DATAWIDTH-1:0] initValue,
    input  logic                 flushReq,
    output logic                 initDone,
    input  logic                 reqA,
    input  logic [ADDRWIDTH-1:0] addrA,
    input  logic [DATAWIDTH-1:0] dataA,
    output logic                 ackA,
    input  logic                 reqB,
    input  logic [ADDRWIDTH-1:0] addrB,
    input  logic [DATAWIDTH-1:0] dataB,
    output logic                 ackB,
    output logic                 ramEnWr,
    output logic [ADDRWIDTH-1:0] ramWrAddr,
    output logic [DATAWIDTH-1:0] ramWrData
);
    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = ADDRWIDTH'(DEPTH - 1);

    ctrlState state, stateNext;
    logic [ADDRWIDTH-1:0] sweepCnt, sweepCntNext;
    logic [DATAWIDTH-1:0] fillValue, fillValueNext;
    logic lastGrant, lastGrantNext;
    logic initDoneNext, ackANext, ackBNext, ramEnWrNext;
    logic [ADDRWIDTH-1:0] ramWrAddrNext;
    logic [DATAWIDTH-1:0] ramWrDataNext;
    logic grantA, grantB;

    rr_arb2 arb (
        .reqA     (reqA),
        .reqB     (reqB),
        .lastGrant(lastGrant),
        .grantA   (grantA),
        .grantB   (grantB)
    );

    always_comb begin
        stateNext     = state;
        sweepCntNext  = sweepCnt;
        fillValueNext = fillValue;
        lastGrantNext = lastGrant;
        initDoneNext  = initDone;
        ackANext      = 1'b0;
        ackBNext      = 1'b0;
        ramEnWrNext   = 1'b0;
        ramWrAddrNext = ramWrAddr;
        ramWrDataNext = ramWrData;
        // A flush outranks sweep completion and user requests alike
        if (state == INIT_START || flushReq) begin
            stateNext     = SWEEP;
            sweepCntNext  = '0;
            fillValueNext = initValue;
            initDoneNext  = 1'b0;
            ramEnWrNext   = 1'b1;
            ramWrAddrNext = '0;
            ramWrDataNext = initValue;
        end else if (state == SWEEP) begin
            if (sweepCnt == LAST_ADDR) begin
                stateNext    = READY;
                initDoneNext = 1'b1;
            end else begin
                sweepCntNext  = sweepCnt + 1'b1;
                ramEnWrNext   = 1'b1;
                ramWrAddrNext = sweepCnt + 1'b1;
                ramWrDataNext = fillValue;
            end
        end else if (grantA || grantB) begin
            ackANext      = grantA;
            ackBNext      = grantB;
            ramEnWrNext   = 1'b1;
            ramWrAddrNext = grantA ? addrA : addrB;
            ramWrDataNext = grantA ? dataA : dataB;
            lastGrantNext = grantA ? GRANT_A : GRANT_B;
        end
    end

    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            state     <= INIT_START;
            sweepCnt  <= '0;
            fillValue <= '0;
            lastGrant <= GRANT_B;
            initDone  <= 1'b0;
            ackA      <= 1'b0;
            ackB      <= 1'b0;
            ramEnWr   <= 1'b0;
            ramWrAddr <= '0;
            ramWrData <= '0;
        end else begin
            state     <= stateNext;
            sweepCnt  <= sweepCntNext;
            fillValue <= fillValueNext;
            lastGrant <= lastGrantNext;
            initDone  <= initDoneNext;
            ackA      <= ackANext;
            ackB      <= ackBNext;
            ramEnWr   <= ramEnWrNext;
            ramWrAddr <= ramWrAddrNext;
            ramWrData <= ramWrDataNext;
        end
    end
endmodule

// File: tb/tb_ram_wr_port_ctrl.sv
// tb_ram_wr_port_ctrl: directed bench for the RAM write-port controller with a
// cycle model for the DEPTH=8 instance and literal checks on both instances.
module tb_ram_wr_port_ctrl;
    import ram_wr_port_ctrl_pkg::*;
    localparam int AW = addrWidthOf(8);

    logic clockCore = 1'b0;
    logic resetCore = 1'b0;
    logic [31:0] initValue = '0;
    logic flushReq = 1'b0;
    logic reqA = 1'b0, reqB = 1'b0;
    logic [AW-1:0] addrA = '0, addrB = '0;
    logic [31:0] dataA = '0, dataB = '0;
    logic initDone, ackA, ackB, ramEnWr;
    logic [AW-1:0] ramWrAddr;
    logic [31:0] ramWrData;
    logic initDone5, ackA5, ackB5, ramEnWr5;
    logic [AW-1:0] ramWrAddr5;
    logic [31:0] ramWrData5;

    int nCmp = 0, nBad = 0, writes5 = 0, bad5 = 0;

    always #5 clockCore = ~clockCore;

    ram_wr_port_ctrl #(.DEPTH(8), .DATAWIDTH(32)) dut (
        .clockCore(clockCore), .resetCore(resetCore), .initValue(initValue),
        .flushReq(flushReq), .initDone(initDone),
        .reqA(reqA), .addrA(addrA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .addrB(addrB), .dataB(dataB), .ackB(ackB),
        .ramEnWr(ramEnWr), .ramWrAddr(ramWrAddr), .ramWrData(ramWrData)
    );

    ram_wr_port_ctrl #(.DEPTH(5), .DATAWIDTH(32)) dut5 (
        .clockCore(clockCore), .resetCore(resetCore), .initValue(initValue),
        .flushReq(1'b0), .initDone(initDone5),
        .reqA(1'b0), .addrA('0), .dataA('0), .ackA(ackA5),
        .reqB(1'b0), .addrB('0), .dataB('0), .ackB(ackB5),
        .ramEnWr(ramEnWr5), .ramWrAddr(ramWrAddr5), .ramWrData(ramWrData5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Model: sweepWrites counts fill writes issued so far (-1 = none since reset)
    int sweepWrites = -1;
    bit mReady = 0, mLastA = 0, mPickA = 0;
    logic [31:0] mFill = '0;
    logic eInit = 0, eAckA = 0, eAckB = 0, eEn = 0;
    logic [AW-1:0] eAddr = '0;
    logic [31:0] eData = '0;

    always @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            sweepWrites = -1; mReady = 0; mLastA = 0;
            eInit = 0; eAckA = 0; eAckB = 0; eEn = 0; eAddr = '0; eData = '0;
        end else begin
            eAckA = 0; eAckB = 0; eEn = 0;
            if (flushReq || sweepWrites < 0) begin
                mReady = 0; mFill = initValue; sweepWrites = 0;
            end
            if (!mReady && sweepWrites < 8) begin
                eEn = 1; eAddr = AW'(sweepWrites); eData = mFill; eInit = 0;
                sweepWrites++;
            end else if (!mReady) begin
                mReady = 1; eInit = 1;
            end else if (reqA || reqB) begin
                mPickA = reqA && (!reqB || !mLastA);
                mLastA = mPickA;
                eAckA = mPickA; eAckB = !mPickA; eEn = 1;
                eAddr = mPickA ? addrA : addrB;
                eData = mPickA ? dataA : dataB;
            end
        end
    end

    always @(negedge clockCore) begin
        chk("initDone", initDone, eInit);
        chk("ackA", ackA, eAckA);
        chk("ackB", ackB, eAckB);
        chk("ramEnWr", ramEnWr, eEn);
        if (eEn) begin
            chk("ramWrAddr", ramWrAddr, eAddr);
            chk("ramWrData", ramWrData, eData);
        end
        chk("ackExclusive", ackA & ackB, 0);
        chk("ackNeedsEn", (ackA | ackB) & !ramEnWr, 0);
        if (ramEnWr5) writes5++;
        if (ramEnWr5 && ramWrAddr5 >= 5) bad5++;
    end

    initial begin
        initValue = 32'hA5A5A5A5;
        repeat (2) @(negedge clockCore);
        chk("rstInitDone", initDone, 0);
        chk("rstAcks", {ackA, ackB}, 0);
        chk("rstEn", ramEnWr, 0);
        chk("rstAddr", ramWrAddr, 0);
        chk("rstData", ramWrData, 0);
        resetCore = 1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clockCore);
            if (c <= 8) begin
                chk("sweepEn", ramEnWr, 1);
                chk("sweepAddr", ramWrAddr, c - 1);
                chk("sweepData", ramWrData, 32'hA5A5A5A5);
            end else chk("sweepEndEn", ramEnWr, 0);
            chk("sweepInitDone", initDone, c == 9);
            chk("sweepNoAck", {ackA, ackB}, 0);
            chk("d5En", ramEnWr5, c <= 5);
            if (c <= 5) begin
                chk("d5Addr", ramWrAddr5, c - 1);
                chk("d5Data", ramWrData5, 32'hA5A5A5A5);
            end
            chk("d5InitDone", initDone5, c >= 6);
            chk("d5NoAck", {ackA5, ackB5}, 0);
            if (c == 4) begin reqB = 1; addrB = 5; dataB = 32'hBBBB0001; end
        end
        chk("d5Writes", writes5, 5);
        @(negedge clockCore);
        chk("pendAckB", ackB, 1);
        chk("pendAddr", ramWrAddr, 5);
        chk("pendData", ramWrData, 32'hBBBB0001);
        addrB = 6; dataB = 32'hBBBB0002;
        reqA = 1; addrA = 2; dataA = 32'hAAAA0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clockCore);
            chk("rrAckA", ackA, k % 2 == 0);
            chk("rrAckB", ackB, k % 2 == 1);
            chk("rrAddr", ramWrAddr, (k % 2 == 0) ? addrA : addrB);
            chk("rrData", ramWrData, (k % 2 == 0) ? dataA : dataB);
            if (k % 2 == 0) begin addrA++; dataA++; end
            else begin addrB++; dataB++; end
        end
        reqA = 0; reqB = 0;
        @(negedge clockCore);
        chk("idleEn", ramEnWr, 0);
        reqA = 1; addrA = 2; dataA = 32'hC0C0C0C0; flushReq = 1; initValue = 0;
        @(negedge clockCore);
        flushReq = 0;
        chk("flushNoAck", ackA, 0);
        chk("flushInitDone", initDone, 0);
        chk("flushAddr", ramWrAddr, 0);
        for (int c = 1; c < 8; c++) begin
            @(negedge clockCore);
            chk("flushSweepAddr", ramWrAddr, c);
            chk("flushSweepData", ramWrData, 0);
            chk("flushSweepNoAck", ackA, 0);
        end
        @(negedge clockCore);
        chk("flushDone", initDone, 1);
        chk("flushDoneNoAck", ackA, 0);
        @(negedge clockCore);
        chk("postFlushAckA", ackA, 1);
        chk("postFlushAddr", ramWrAddr, 2);
        chk("postFlushData", ramWrData, 32'hC0C0C0C0);
        reqA = 0; initValue = 32'h12345678; flushReq = 1;
        @(negedge clockCore);
        flushReq = 0;
        repeat (4) @(negedge clockCore);
        chk("preRstAddr", ramWrAddr, 4);
        #2 resetCore = 0;
        #1;
        chk("midRstInitDone", initDone, 0);
        chk("midRstEn", ramEnWr, 0);
        chk("midRstAddr", ramWrAddr, 0);
        chk("midRstData", ramWrData, 0);
        @(negedge clockCore);
        resetCore = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clockCore);
            chk("reSweepAddr", ramWrAddr, c);
            chk("reSweepData", ramWrData, 32'h12345678);
        end
        @(negedge clockCore);
        chk("reSweepDone", initDone, 1);
        repeat (2) @(negedge clockCore);
        chk("d5Range", bad5, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
